latch_wr_ctrl: RTL and testbench

Write sequencer that sits directly upstream of a bank of transparent-high LATCH cells. It drives their shared data (D) and per-latch enables (CLK). It accepts single-word write requests over a ready/valid handshake. For each request it presents the data with a programmable setup margin, then raises exactly one enable for a programmable minimum high width, then holds data stable after the enable falls. Latch setup, hold and minimum-pulse-width requirements are therefore met by construction, in whole clock cycles.

---
 rtl/latch_wr_ctrl_if.sv | 29 ++
 rtl/latch_wr_ctrl.sv | 112 +++++++++++
 tb/tb_latch_wr_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/latch_wr_ctrl_if.sv
// Write-request / latch-bank bus between a requester and latch_wr_ctrl.
// Carries the request handshake plus the registered drive to the latch bank.
interface latch_wr_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int NLATCH = 4,
    parameter int AW     = 2
);
    // Handshake: a request is taken on a rising CLK edge where REQ=1 and
    // READY=1. While READY=0 the controller ignores REQ/ADDR/WDATA, and the
    // requester keeps REQ high with stable ADDR/WDATA until it is taken.
    logic              REQ;
    logic [AW-1:0]     ADDR;
    logic [WIDTH-1:0]  WDATA;
    logic              READY;
    logic [WIDTH-1:0]  LD;
    logic [NLATCH-1:0] LEN;
    logic              DONE;
    logic              ERR;

    modport master (
        output REQ, ADDR, WDATA,
        input  READY, LD, LEN, DONE, ERR
    );

    modport slave (
        input  REQ, ADDR, WDATA,
        output READY, LD, LEN, DONE, ERR
    );
endinterface

// File: rtl/latch_wr_ctrl.sv
// Write sequencer for a bank of transparent-high latches: presents data, pulses
// one enable for a fixed width, then holds data, all in whole clock cycles.
module latch_wr_ctrl #(
    parameter int WIDTH  = 8,
    parameter int NLATCH = 4,
    parameter int AW     = 2,
    parameter int SU_CYC = 1,
    parameter int PW_CYC = 2
) (
    input  logic          CLK,
    input  logic          R,
    latch_wr_ctrl_if.slave bus,
    output logic [1:0]    dbg_state
);

    localparam int MAXC = (SU_CYC > PW_CYC) ? SU_CYC : PW_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [AW:0] NL_W = (AW+1)'(NLATCH);

    // Encoding is visible on dbg_state; IDLE is 0.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     addr_q;
    logic              ready_q;
    logic [WIDTH-1:0]  ld_q;
    logic [NLATCH-1:0] len_q;
    logic              done_q;
    logic              err_q;

    logic              addr_ok;
    logic [NLATCH-1:0] onehot;

    assign addr_ok = ({1'b0, bus.ADDR} < NL_W);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NLATCH; i++) begin
            if (addr_q == AW'(i)) onehot[i] = 1'b1;
        end
    end

    // LEN is only ever loaded from a one-hot of an in-range address, and the
    // async reset drops it without waiting for a clock edge.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            ready_q <= 1'b1;
            ld_q    <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.REQ && ready_q) begin
                        if (addr_ok) begin
                            ld_q    <= bus.WDATA;
                            addr_q  <= bus.ADDR;
                            ready_q <= 1'b0;
                            cnt     <= CW'(SU_CYC - 1);
                            state   <= SETUP;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        len_q <= onehot;
                        cnt   <= CW'(PW_CYC - 1);
                        state <= OPEN;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                OPEN: begin
                    if (cnt == '0) begin
                        len_q <= '0;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    ready_q <= 1'b1;
                    done_q  <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.READY = ready_q;
    assign bus.LD    = ld_q;
    assign bus.LEN   = len_q;
    assign bus.DONE  = done_q;
    assign bus.ERR   = err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_latch_wr_ctrl.sv
// Bench for latch_wr_ctrl: three configurations share one request stream, each
// checked every cycle against a timeline model of its own write sequence.
module tb_latch_wr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       chk_en = 1'b0;

  logic       ready_o[3], done_o[3], err_o[3];
  logic [7:0] ld_o[3];
  logic [3:0] len_o[3];
  logic [1:0] dbg_o[3];
  logic       exp_ready[3], exp_done[3], exp_err[3];
  logic [7:0] exp_ld[3];
  logic [3:0] exp_len[3];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Config 0: defaults. Config 1: SU=3, PW=1. Config 2: NLATCH=3.
  for (genvar gi = 0; gi < 3; gi++) begin : gen_cfg
    localparam int SU = (gi == 1) ? 3 : 1;
    localparam int PW = (gi == 1) ? 1 : 2;
    localparam int NL = (gi == 2) ? 3 : 4;

    latch_wr_ctrl_if #(.WIDTH(8), .NLATCH(NL), .AW(2)) bus ();

    latch_wr_ctrl #(
      .WIDTH(8), .NLATCH(NL), .AW(2), .SU_CYC(SU), .PW_CYC(PW)
    ) u_dut (
      .CLK      (clk),
      .R        (rst_n),
      .bus      (bus.slave),
      .dbg_state(dbg_o[gi])
    );

    assign bus.REQ   = req;
    assign bus.ADDR  = addr;
    assign bus.WDATA = wdata;
    assign ready_o[gi] = bus.READY;
    assign done_o[gi]  = bus.DONE;
    assign err_o[gi]   = bus.ERR;
    assign ld_o[gi]    = bus.LD;
    assign len_o[gi]   = 4'(bus.LEN);

    // Reference: k counts edges since the last accepted write; every output
    // is a function of where k sits on that write's timeline.
    logic       busy;
    int         k;
    logic [7:0] m_ld;
    logic [1:0] m_addr;
    logic       m_err;
    logic       m_ready;

    assign m_ready = !busy || (k >= SU + PW + 1);

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy   <= 1'b0;
        k      <= 0;
        m_ld   <= 8'h00;
        m_addr <= 2'd0;
        m_err  <= 1'b0;
      end else begin
        m_err <= 1'b0;
        k     <= k + 1;
        if (req && m_ready) begin
          if (int'(addr) < NL) begin
            busy   <= 1'b1;
            k      <= 0;
            m_ld   <= wdata;
            m_addr <= addr;
          end else begin
            m_err <= 1'b1;
          end
        end
      end
    end

    assign exp_ready[gi] = m_ready;
    assign exp_done[gi]  = busy && (k == SU + PW + 1);
    assign exp_err[gi]   = m_err;
    assign exp_ld[gi]    = m_ld;
    assign exp_len[gi]   = (busy && k >= SU && k < SU + PW) ? 4'(1 << m_addr) : 4'd0;
  end

  // Scoreboard: every DUT output against its model, once per cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < 3; g++) begin
        check($sformatf("ready%0d", g), 32'(ready_o[g]), 32'(exp_ready[g]));
        check($sformatf("done%0d", g),  32'(done_o[g]),  32'(exp_done[g]));
        check($sformatf("err%0d", g),   32'(err_o[g]),   32'(exp_err[g]));
        check($sformatf("ld%0d", g),    32'(ld_o[g]),    32'(exp_ld[g]));
        check($sformatf("len%0d", g),   32'(len_o[g]),   32'(exp_len[g]));
        check($sformatf("onehot%0d", g), 32'($countones(len_o[g]) <= 1), 32'd1);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    req = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (ready_o[0] && ready_o[1] && ready_o[2]) break;
    end
    check("idle_wait", 32'(ready_o[0] && ready_o[1] && ready_o[2]), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    addr  = 2'd0;
    wdata = 8'h00;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_ready", 32'(ready_o[g]), 32'd1);
      check("rst_ld",    32'(ld_o[g]),    32'd0);
      check("rst_len",   32'(len_o[g]),   32'd0);
      check("rst_done",  32'(done_o[g]),  32'd0);
      check("rst_err",   32'(err_o[g]),   32'd0);
      check("rst_state", 32'(dbg_o[g]),   32'd0);
    end
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Single write (2, A5); the value after edge c is sampled at loop step c.
    req = 1'b1; addr = 2'd2; wdata = 8'hA5;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 0) req = 1'b0;
      check("sw_ld",     32'(ld_o[0]),    32'hA5);
      check("sw_len",    32'(len_o[0]),   (c == 1 || c == 2) ? 32'h4 : 32'h0);
      check("sw_done",   32'(done_o[0]),  32'(c == 4));
      check("sw_ready",  32'(ready_o[0]), 32'(c >= 4));
      check("swp_len",   32'(len_o[1]),   (c == 3) ? 32'h4 : 32'h0);
      check("swp_done",  32'(done_o[1]),  32'(c == 5));
    end
    wait_idle();

    // Out-of-range address on the 3-latch bank.
    req = 1'b1; addr = 2'd3; wdata = 8'hFF;
    @(negedge clk);
    req = 1'b0;
    check("oor_err",   32'(err_o[2]),   32'd1);
    check("oor_len",   32'(len_o[2]),   32'd0);
    check("oor_ld",    32'(ld_o[2]),    32'hA5);
    check("oor_ready", 32'(ready_o[2]), 32'd1);
    check("oor_done",  32'(done_o[2]),  32'd0);
    @(negedge clk);
    check("oor_err_end", 32'(err_o[2]), 32'd0);
    wait_idle();

    // Back-to-back with REQ held: (0,11) then (3,22), second taken at edge 5.
    req = 1'b1; addr = 2'd0; wdata = 8'h11;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      if (c == 0) begin addr = 2'd3; wdata = 8'h22; end
      check("b2b_len",   32'(len_o[0]),   (c == 1 || c == 2) ? 32'h1 : (c == 6 || c == 7) ? 32'h8 : 32'h0);
      check("b2b_ld",    32'(ld_o[0]),    (c < 5) ? 32'h11 : 32'h22);
      check("b2b_ready", 32'(ready_o[0]), 32'(c == 4 || c == 9));
      if (c == 5) req = 1'b0;
    end
    wait_idle();

    // Requests toggled while busy must be ignored.
    req = 1'b1; addr = 2'd1; wdata = 8'h3C;
    @(negedge clk);
    for (int c = 1; c <= 3; c++) begin
      req   = (c == 3) ? 1'b0 : 1'($urandom_range(0, 1));
      addr  = 2'd2;
      wdata = 8'(c * 8'h33);
      @(negedge clk);
      check("tog_ld", 32'(ld_o[0]), 32'h3C);
    end
    wait_idle();
    check("tog_ld_end", 32'(ld_o[0]), 32'h3C);

    // Reset in the middle of an enable pulse.
    req = 1'b1; addr = 2'd1; wdata = 8'h77;
    @(negedge clk);
    req = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (len_o[0] != 4'd0) break;
      @(negedge clk);
    end
    check("mid_open_len", 32'(len_o[0]), 32'h2);
    #2 rst_n = 1'b0;
    #1 check("async_len", 32'(len_o[0]), 32'h0);
    check("async_ready", 32'(ready_o[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(ready_o[0]), 32'd1);
    check("post_rst_ld",    32'(ld_o[0]),    32'd0);
    check("post_rst_done",  32'(done_o[0]),  32'd0);
    check("post_rst_err",   32'(err_o[0]),   32'd0);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      req   = ($urandom_range(0, 3) != 0);
      addr  = 2'($urandom_range(0, 3));
      wdata = 8'($urandom_range(0, 255));
    end
    wait_idle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
